llc_rst_flush_ctrl: RTL and testbench

- Sequencer for the LLC set-walk operations: post-reset invalidation of every set, and full-cache flush (write back dirty lines, then invalidate).
- Owns the set walk counter and the rst_stall/flush_stall flags that gate the request decoder.
- Drives the tag/state array via three requests: set read, per-way writeback and per-set invalidate.

---
 rtl/llc_rst_flush_ctrl_pkg.sv | 21 ++
 rtl/llc_rst_flush_ctrl_way_enc.sv | 24 ++
 rtl/llc_rst_flush_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_llc_rst_flush_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_rst_flush_ctrl_pkg.sv
// LLC reset/flush sequencer shared definitions.
// Default geometry, set/way types and controller state encoding.
package llc_rst_flush_ctrl_pkg;

    localparam int LLC_SET_BITS = 10;
    localparam int LLC_NUM_WAYS = 16;
    localparam int LLC_WAY_BITS = 4;

    typedef logic [LLC_SET_BITS-1:0] llc_set_t;
    typedef logic [LLC_WAY_BITS-1:0] llc_way_t;

    typedef enum logic [2:0] {
        IDLE,
        RST_WALK,
        FL_READ,
        FL_WAIT,
        FL_SCAN,
        FL_INV
    } llc_fsm_e;

endpackage

// File: rtl/llc_rst_flush_ctrl_way_enc.sv
// Lowest-set-bit encoder over the ways of one set.
// The caller clears the winning bit once it has been consumed.
module llc_way_prio_enc #(
    parameter int LLC_WAYS = 16,
    parameter int WAY_BITS = 4
) (
    input  logic [LLC_WAYS-1:0] req_i,
    output logic [WAY_BITS-1:0] way_o,
    output logic                found_o
);

    // Scan downwards so the lowest requesting way wins.
    always_comb begin
        way_o   = '0;
        found_o = 1'b0;
        for (int i = LLC_WAYS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                way_o   = WAY_BITS'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/llc_rst_flush_ctrl.sv
// Set-walk sequencer: post-reset invalidation of every set and
// full-cache flush (writeback dirty ways, then invalidate the set).
module llc_rst_flush_ctrl
    import llc_rst_flush_ctrl_pkg::*;
#(
    parameter int SET_BITS = LLC_SET_BITS,
    parameter int LLC_WAYS = LLC_NUM_WAYS,
    parameter int WAY_BITS = LLC_WAY_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_state_i,
    input  logic                flush_req_i,
    output logic                rd_set_valid_o,
    input  logic                rd_set_ready_i,
    output logic [SET_BITS-1:0] rd_set_o,
    input  logic                rd_resp_valid_i,
    input  logic [LLC_WAYS-1:0] rd_valid_ways_i,
    input  logic [LLC_WAYS-1:0] rd_dirty_ways_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [SET_BITS-1:0] wb_set_o,
    output logic [WAY_BITS-1:0] wb_way_o,
    output logic                inv_valid_o,
    input  logic                inv_ready_i,
    output logic [SET_BITS-1:0] inv_set_o,
    output logic [LLC_WAYS-1:0] inv_mask_o,
    output logic                rst_stall_o,
    output logic                flush_stall_o,
    output logic                flush_done_o
);

    localparam logic [SET_BITS-1:0] LAST_SET = '1;

    llc_fsm_e            state_q, state_d;
    logic [SET_BITS-1:0] set_cnt_q, set_cnt_d;
    logic                rst_stall_q, rst_stall_d;
    logic                pend_q, pend_d;
    logic [LLC_WAYS-1:0] vmask_q, vmask_d;
    logic [LLC_WAYS-1:0] dmask_q, dmask_d;

    logic                rd_v_q, rd_v_d;
    logic                wb_v_q, wb_v_d;
    logic                inv_v_q, inv_v_d;
    logic                done_q, done_d;
    logic [WAY_BITS-1:0] way_q, way_d;
    logic [LLC_WAYS-1:0] inv_mask_q, inv_mask_d;

    logic                rd_hs, wb_hs, inv_hs;
    logic                flush_acc, adv, fin;
    logic [WAY_BITS-1:0] enc_way;
    logic                enc_found;

    assign rd_hs  = rd_v_q & rd_set_ready_i;
    assign wb_hs  = wb_v_q & wb_ready_i;
    assign inv_hs = inv_v_q & inv_ready_i;

    // Only one flush is ever outstanding; later requests are dropped.
    assign flush_acc = flush_req_i & ~pend_q &
                       ((state_q == IDLE) | (state_q == RST_WALK));

    // The next dirty way is encoded from the next mask so that the
    // writeback request is registered together with the mask.
    llc_way_prio_enc #(
        .LLC_WAYS (LLC_WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_enc (
        .req_i   (dmask_d),
        .way_o   (enc_way),
        .found_o (enc_found)
    );

    // State and output registers; reset discards all progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RST_WALK;
            set_cnt_q   <= '0;
            rst_stall_q <= 1'b1;
            pend_q      <= 1'b0;
            vmask_q     <= '0;
            dmask_q     <= '0;
            rd_v_q      <= 1'b0;
            wb_v_q      <= 1'b0;
            inv_v_q     <= 1'b0;
            done_q      <= 1'b0;
            way_q       <= '0;
            inv_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            set_cnt_q   <= set_cnt_d;
            rst_stall_q <= rst_stall_d;
            pend_q      <= pend_d;
            vmask_q     <= vmask_d;
            dmask_q     <= dmask_d;
            rd_v_q      <= rd_v_d;
            wb_v_q      <= wb_v_d;
            inv_v_q     <= inv_v_d;
            done_q      <= done_d;
            way_q       <= way_d;
            inv_mask_q  <= inv_mask_d;
        end
    end

    // Next-state logic: walk sets, scan dirty ways, restart on request.
    always_comb begin
        state_d     = state_q;
        set_cnt_d   = set_cnt_q;
        rst_stall_d = rst_stall_q;
        pend_d      = pend_q | flush_acc;
        vmask_d     = vmask_q;
        dmask_d     = dmask_q;
        adv         = 1'b0;
        fin         = 1'b0;

        unique case (state_q)
            RST_WALK: begin
                if (inv_hs) begin
                    if (set_cnt_q == LAST_SET) begin
                        set_cnt_d   = '0;
                        rst_stall_d = 1'b0;
                        state_d     = pend_d ? FL_READ : IDLE;
                    end else begin
                        set_cnt_d = set_cnt_q + 1'b1;
                    end
                end
            end
            IDLE: begin
                if (pend_d) state_d = FL_READ;
            end
            FL_READ: begin
                if (rd_hs) state_d = FL_WAIT;
            end
            FL_WAIT: begin
                if (rd_resp_valid_i) begin
                    vmask_d = rd_valid_ways_i;
                    dmask_d = rd_valid_ways_i & rd_dirty_ways_i;
                    state_d = FL_SCAN;
                end
            end
            FL_SCAN: begin
                if (dmask_q != '0) begin
                    if (wb_hs)
                        dmask_d = dmask_q & ~(LLC_WAYS'(1) << way_q);
                end else if (vmask_q != '0) begin
                    state_d = FL_INV;
                end else begin
                    adv = 1'b1;
                end
            end
            FL_INV: begin
                if (inv_hs) adv = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if (set_cnt_q == LAST_SET) begin
                set_cnt_d = '0;
                pend_d    = 1'b0;
                fin       = 1'b1;
                state_d   = IDLE;
            end else begin
                set_cnt_d = set_cnt_q + 1'b1;
                state_d   = FL_READ;
            end
        end

        if (rst_state_i) begin
            state_d     = RST_WALK;
            set_cnt_d   = '0;
            rst_stall_d = 1'b1;
            pend_d      = 1'b0;
        end
    end

    // Registered outputs follow the next state; a restart drops all valids.
    always_comb begin
        rd_v_d     = ~rst_state_i & (state_d == FL_READ);
        wb_v_d     = ~rst_state_i & (state_d == FL_SCAN) & enc_found;
        inv_v_d    = ~rst_state_i &
                     ((state_d == RST_WALK) | (state_d == FL_INV));
        done_d     = ~rst_state_i & fin;
        way_d      = enc_way;
        inv_mask_d = (state_d == FL_INV) ? vmask_d : '1;
    end

    assign rd_set_valid_o = rd_v_q;
    assign rd_set_o       = set_cnt_q;
    assign wb_valid_o     = wb_v_q;
    assign wb_set_o       = set_cnt_q;
    assign wb_way_o       = way_q;
    assign inv_valid_o    = inv_v_q;
    assign inv_set_o      = set_cnt_q;
    assign inv_mask_o     = inv_mask_q;
    assign rst_stall_o    = rst_stall_q;
    assign flush_stall_o  = pend_q;
    assign flush_done_o   = done_q;

endmodule

// File: tb/tb_llc_rst_flush_ctrl.sv
// Directed bench for llc_rst_flush_ctrl with 4 sets x 4 ways.
// Read responses come from a small per-set table.
module tb_llc_rst_flush_ctrl;

    localparam int SB = 2;
    localparam int NW = 4;
    localparam int WB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          rst_state_i;
    logic          flush_req_i;
    logic          rd_set_valid_o;
    logic          rd_set_ready_i;
    logic [SB-1:0] rd_set_o;
    logic          rd_resp_valid_i;
    logic [NW-1:0] rd_valid_ways_i;
    logic [NW-1:0] rd_dirty_ways_i;
    logic          wb_valid_o;
    logic          wb_ready_i;
    logic [SB-1:0] wb_set_o;
    logic [WB-1:0] wb_way_o;
    logic          inv_valid_o;
    logic          inv_ready_i;
    logic [SB-1:0] inv_set_o;
    logic [NW-1:0] inv_mask_o;
    logic          rst_stall_o;
    logic          flush_stall_o;
    logic          flush_done_o;

    always #5 clk = ~clk;

    llc_rst_flush_ctrl #(
        .SET_BITS (SB),
        .LLC_WAYS (NW),
        .WAY_BITS (WB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rst_state_i     (rst_state_i),
        .flush_req_i     (flush_req_i),
        .rd_set_valid_o  (rd_set_valid_o),
        .rd_set_ready_i  (rd_set_ready_i),
        .rd_set_o        (rd_set_o),
        .rd_resp_valid_i (rd_resp_valid_i),
        .rd_valid_ways_i (rd_valid_ways_i),
        .rd_dirty_ways_i (rd_dirty_ways_i),
        .wb_valid_o      (wb_valid_o),
        .wb_ready_i      (wb_ready_i),
        .wb_set_o        (wb_set_o),
        .wb_way_o        (wb_way_o),
        .inv_valid_o     (inv_valid_o),
        .inv_ready_i     (inv_ready_i),
        .inv_set_o       (inv_set_o),
        .inv_mask_o      (inv_mask_o),
        .rst_stall_o     (rst_stall_o),
        .flush_stall_o   (flush_stall_o),
        .flush_done_o    (flush_done_o)
    );

    typedef struct {
        int kind;
        int set;
        int val;
    } ev_t;

    int  checks = 0;
    int  errors = 0;
    int  ndone  = 0;
    bit  resp_en = 1'b1;
    bit  dirty2  = 1'b0;
    ev_t evq[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tag-array contents: {valid ways, dirty ways} per set.
    function automatic logic [7:0] resp_of(int s);
        if (s == 1) return {4'b1011, 4'b1010};
        if (s == 2 && dirty2) return {4'b0100, 4'b0100};
        return 8'h00;
    endfunction

    // One clock: log handshakes, then answer a completed set read.
    task automatic cyc();
        bit hs;
        int hs_set;
        chk("onehot", 32'($countones({rd_set_valid_o, wb_valid_o,
                                      inv_valid_o}) <= 1), 1);
        hs     = rd_set_valid_o && rd_set_ready_i;
        hs_set = int'(rd_set_o);
        if (wb_valid_o && wb_ready_i)
            evq.push_back('{1, int'(wb_set_o), int'(wb_way_o)});
        if (inv_valid_o && inv_ready_i)
            evq.push_back('{2, int'(inv_set_o), int'(inv_mask_o)});
        if (flush_done_o) ndone++;
        @(posedge clk);
        #1;
        rd_resp_valid_i = hs && resp_en;
        {rd_valid_ways_i, rd_dirty_ways_i} = resp_of(hs_set);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b0;
        rst_state_i     = 1'b0;
        flush_req_i     = 1'b0;
        rd_set_ready_i  = 1'b0;
        rd_resp_valid_i = 1'b0;
        rd_valid_ways_i = '0;
        rd_dirty_ways_i = '0;
        wb_ready_i      = 1'b0;
        inv_ready_i     = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // Reset values
        chk("rst_stall", 32'(rst_stall_o), 1);
        chk("rst_fstall", 32'(flush_stall_o), 0);
        chk("rst_rd_v", 32'(rd_set_valid_o), 0);
        chk("rst_wb_v", 32'(wb_valid_o), 0);
        chk("rst_inv_v", 32'(inv_valid_o), 0);
        chk("rst_done", 32'(flush_done_o), 0);

        // Post-reset walk: one set per cycle
        rst = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("walk_v", 32'(inv_valid_o), 1);
            chk("walk_set", 32'(inv_set_o), i);
            chk("walk_mask", 32'(inv_mask_o), 4'hF);
            chk("walk_stall", 32'(rst_stall_o), 1);
            cyc();
        end
        chk("walk_stall_clr", 32'(rst_stall_o), 0);
        chk("walk_end_v", 32'(inv_valid_o), 0);

        // Flush from IDLE, all readies high
        rd_set_ready_i = 1'b1;
        wb_ready_i     = 1'b1;
        evq.delete();
        flush_req_i = 1'b1;
        cyc();
        flush_req_i = 1'b0;
        chk("fl_stall", 32'(flush_stall_o), 1);
        chk("fl_rd_v", 32'(rd_set_valid_o), 1);
        chk("fl_rd_set", 32'(rd_set_o), 0);
        for (int k = 0; k < 80; k++) begin
            if (flush_done_o) break;
            cyc();
        end
        chk("fl_done", 32'(flush_done_o), 1);
        chk("fl_stall_clr", 32'(flush_stall_o), 0);
        chk("fl_evcount", 32'(evq.size()), 3);
        if (evq.size() == 3) begin
            chk("fl_ev0", 32'({evq[0].kind, evq[0].set, evq[0].val} == {1, 1, 1}), 1);
            chk("fl_ev1", 32'({evq[1].kind, evq[1].set, evq[1].val} == {1, 1, 3}), 1);
            chk("fl_ev2", 32'({evq[2].kind, evq[2].set, evq[2].val} == {2, 1, 11}), 1);
        end
        cyc();
        chk("fl_done_pulse", 32'(flush_done_o), 0);

        // Writeback held off for 5 cycles
        wb_ready_i = 1'b0;
        evq.delete();
        flush_req_i = 1'b1;
        cyc();
        flush_req_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (wb_valid_o) break;
            cyc();
        end
        chk("hold_seen", 32'(wb_valid_o), 1);
        repeat (5) begin
            chk("hold_v", 32'(wb_valid_o), 1);
            chk("hold_set", 32'(wb_set_o), 1);
            chk("hold_way", 32'(wb_way_o), 1);
            chk("hold_rd", 32'(rd_set_valid_o), 0);
            chk("hold_inv", 32'(inv_valid_o), 0);
            cyc();
        end
        wb_ready_i = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (flush_done_o) break;
            cyc();
        end
        chk("hold_done", 32'(flush_done_o), 1);
        chk("hold_evcount", 32'(evq.size()), 3);

        // Flush requested during a restarted walk
        rst_state_i = 1'b1;
        cyc();
        rst_state_i = 1'b0;
        chk("rw_inv_drop", 32'(inv_valid_o), 0);
        chk("rw_stall", 32'(rst_stall_o), 1);
        cyc();
        cyc();
        cyc();
        chk("rw_set2", 32'(inv_set_o), 2);
        flush_req_i = 1'b1;
        cyc();
        flush_req_i = 1'b0;
        chk("rw_fstall", 32'(flush_stall_o), 1);
        chk("rw_rstall", 32'(rst_stall_o), 1);
        chk("rw_set3", 32'(inv_set_o), 3);
        cyc();
        chk("rw_stall_clr", 32'(rst_stall_o), 0);
        chk("rw_rd_v", 32'(rd_set_valid_o), 1);
        chk("rw_rd_set", 32'(rd_set_o), 0);
        chk("rw_inv_v", 32'(inv_valid_o), 0);

        // Restart while writing back set 2
        dirty2 = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (wb_valid_o && wb_set_o == 2) break;
            cyc();
        end
        chk("sc_wb2", 32'(wb_valid_o && wb_set_o == 2), 1);
        chk("sc_way2", 32'(wb_way_o), 2);
        wb_ready_i  = 1'b0;
        rst_state_i = 1'b1;
        ndone = 0;
        cyc();
        rst_state_i = 1'b0;
        dirty2 = 1'b0;
        chk("sc_wb_drop", 32'(wb_valid_o), 0);
        chk("sc_inv_v", 32'(inv_valid_o), 0);
        chk("sc_rstall", 32'(rst_stall_o), 1);
        chk("sc_fstall", 32'(flush_stall_o), 0);
        chk("sc_set0", 32'(inv_set_o), 0);
        cyc();
        chk("sc_walk_v", 32'(inv_valid_o), 1);
        chk("sc_walk_set", 32'(inv_set_o), 0);
        repeat (4) cyc();
        chk("sc_walk_end", 32'(rst_stall_o), 0);
        chk("sc_no_flush", 32'(rd_set_valid_o), 0);
        chk("sc_fstall2", 32'(flush_stall_o), 0);
        chk("sc_no_done", 32'(ndone), 0);

        // Reset pulse in FL_WAIT, then a stale read response
        wb_ready_i = 1'b1;
        resp_en    = 1'b0;
        flush_req_i = 1'b1;
        cyc();
        flush_req_i = 1'b0;
        chk("fw_rd_v", 32'(rd_set_valid_o), 1);
        chk("fw_rd_set", 32'(rd_set_o), 0);
        cyc();
        chk("fw_wait", 32'(rd_set_valid_o), 0);
        chk("fw_fstall", 32'(flush_stall_o), 1);
        rst = 1'b0;
        cyc();
        chk("fw_rstall", 32'(rst_stall_o), 1);
        chk("fw_fstall_clr", 32'(flush_stall_o), 0);
        chk("fw_rd_v0", 32'(rd_set_valid_o), 0);
        chk("fw_wb_v0", 32'(wb_valid_o), 0);
        chk("fw_inv_v0", 32'(inv_valid_o), 0);
        chk("fw_done0", 32'(flush_done_o), 0);
        chk("fw_set0", 32'(inv_set_o), 0);
        rst = 1'b1;
        rd_resp_valid_i = 1'b1;
        rd_valid_ways_i = 4'hF;
        rd_dirty_ways_i = 4'hF;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("fw_walk_v", 32'(inv_valid_o), 1);
            chk("fw_walk_set", 32'(inv_set_o), i);
            chk("fw_walk_wb", 32'(wb_valid_o), 0);
            cyc();
        end
        chk("fw_idle_stall", 32'(rst_stall_o), 0);
        chk("fw_idle_rd", 32'(rd_set_valid_o), 0);
        chk("fw_idle_wb", 32'(wb_valid_o), 0);
        chk("fw_idle_fstall", 32'(flush_stall_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
